// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, parity modes and bit-period helper.
// The receiver imports the same encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    localparam int BIT_CNT_W = 19;

    // Reload value for one bit period: eff_prescale*8 - 1, a zero prescale acting as 1.
    function automatic logic [BIT_CNT_W-1:0] bit_reload(input logic [15:0] prescale);
        logic [BIT_CNT_W-1:0] eff;
        eff = (prescale == 16'd0) ? BIT_CNT_W'(1) : BIT_CNT_W'(prescale);
        return (eff << 3) - BIT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-period down-counter; bit_end_o pulses on the cycle the count is zero,
// which is also the cycle it reloads.
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] prescale_i,
    input  logic        run_i,
    output logic        bit_end_o
);

    logic [BIT_CNT_W-1:0] reload_q, reload_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            reload_d = bit_reload(prescale_i);
            cnt_d    = bit_reload(prescale_i);
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - BIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bit_end_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: AXI-Stream beats in, LSB-first frames with optional parity and
// one or two stop bits out on txd. All outputs are registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale
);

    localparam logic [3:0] LAST_DATA_IDX = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] LAST_STOP_IDX = 4'(STOP_BITS - 1);

    uart_tx_state_t        state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic                  txd_q, txd_d;
    logic                  busy_q, busy_d;
    logic                  tready_q, tready_d;
    logic                  timer_load;
    logic                  bit_end;
    logic                  parity_bit;

    uart_bit_timer u_bit_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .prescale_i (prescale),
        .run_i      (state_q != ST_IDLE),
        .bit_end_o  (bit_end)
    );

    // Taken from the latched beat, since the shift register is consumed by then.
    assign parity_bit = (PARITY == PARITY_ODD) ? ~^data_q : ^data_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tready_d   = tready_q;
        timer_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                txd_d    = 1'b1;
                busy_d   = 1'b0;
                tready_d = 1'b1;
                if (s_axis_tvalid && tready_q) begin
                    timer_load = 1'b1;
                    shreg_d    = s_axis_tdata;
                    data_d     = s_axis_tdata;
                    tready_d   = 1'b0;
                    busy_d     = 1'b1;
                    txd_d      = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = 4'd0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q < LAST_DATA_IDX) begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_idx_d = bit_idx_q + 4'd1;
                    end else if (PARITY != PARITY_NONE) begin
                        txd_d   = parity_bit;
                        state_d = ST_PARITY;
                    end else begin
                        txd_d     = 1'b1;
                        bit_idx_d = 4'd0;
                        state_d   = ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    txd_d     = 1'b1;
                    bit_idx_d = 4'd0;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_STOP_IDX) begin
                        tready_d = 1'b1;
                        busy_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            data_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            tready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            tready_q  <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 instance plus an odd-parity, two-stop-bit instance,
// checked cycle by cycle against hand-built frame bit lists.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] prescale;
    logic [7:0]  tdata0, tdata1;
    logic        tvalid0, tvalid1;
    logic        tready0, tready1;
    logic        txd0, txd1;
    logic        busy0, busy1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata0),
        .s_axis_tvalid (tvalid0),
        .s_axis_tready (tready0),
        .txd           (txd0),
        .busy          (busy0),
        .prescale      (prescale)
    );

    uart_tx #(.DATA_WIDTH(8), .PARITY(2), .STOP_BITS(2)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (tdata1),
        .s_axis_tvalid (tvalid1),
        .s_axis_tready (tready1),
        .txd           (txd1),
        .busy          (busy1),
        .prescale      (prescale)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_txd(input int sel);
        return (sel != 0) ? txd1 : txd0;
    endfunction

    function automatic logic cur_busy(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic cur_tready(input int sel);
        return (sel != 0) ? tready1 : tready0;
    endfunction

    task automatic set_beat(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin
            tvalid1 = v;
            tdata1  = d;
        end else begin
            tvalid0 = v;
            tdata0  = d;
        end
    endtask

    task automatic wait_ready(input int sel);
        int n = 0;
        while (!cur_tready(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("ready_wait%0d", sel), 32'(cur_tready(sel)), 32'd1);
    endtask

    // Called at a negedge with tready high; drives the beat and checks txd every cycle.
    task automatic run_frame(input string name, input int sel, input logic [7:0] data,
                             input int eff, input int par, input int stops,
                             input bit hold, input logic [7:0] nxt,
                             input int chg_at, input logic [15:0] chg_psc,
                             input int abort_at);
        logic [11:0] bits;
        int nb, bl, f;
        bl   = eff * 8;
        bits = '1;
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = data[i];
            nb++;
        end
        if (par != 0) begin
            bits[nb] = (par == 2) ? ~^data : ^data;
            nb++;
        end
        for (int s = 0; s < stops; s++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        f = nb * bl;
        set_beat(sel, 1'b1, data);
        @(posedge clk);
        @(negedge clk);
        if (hold) set_beat(sel, 1'b1, nxt);
        else      set_beat(sel, 1'b0, data);
        for (int k = 0; k < f; k++) begin
            if (k == abort_at) return;
            if (k == chg_at) prescale = chg_psc;
            chk($sformatf("%s txd[%0d]", name, k), 32'(cur_txd(sel)), 32'(bits[k / bl]));
            if (k == 0 || k == f - 1) begin
                chk($sformatf("%s busy[%0d]", name, k), 32'(cur_busy(sel)), 32'd1);
                chk($sformatf("%s tready[%0d]", name, k), 32'(cur_tready(sel)), 32'd0);
            end
            @(negedge clk);
        end
        chk($sformatf("%s end_txd", name), 32'(cur_txd(sel)), 32'd1);
        chk($sformatf("%s end_busy", name), 32'(cur_busy(sel)), 32'd0);
        chk($sformatf("%s end_tready", name), 32'(cur_tready(sel)), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        prescale = 16'd1;
        set_beat(0, 1'b0, 8'h00);
        set_beat(1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst txd0", 32'(txd0), 32'd1);
        chk("rst busy0", 32'(busy0), 32'd0);
        chk("rst tready0", 32'(tready0), 32'd0);
        chk("rst txd1", 32'(txd1), 32'd1);
        chk("rst tready1", 32'(tready1), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst tready0", 32'(tready0), 32'd1);
        chk("post_rst tready1", 32'(tready1), 32'd1);

        // 0x55 at prescale 1: alternating bits, 80-cycle frame
        wait_ready(0);
        run_frame("p1_55", 0, 8'h55, 1, 0, 1, 1'b0, 8'h00, -1, 16'd0, -1);

        // prescale 0 clamps to 1
        prescale = 16'd0;
        wait_ready(0);
        run_frame("p0_55", 0, 8'h55, 1, 0, 1, 1'b0, 8'h00, -1, 16'd0, -1);

        // Back-to-back with tvalid held: one idle cycle between frames
        prescale = 16'd2;
        wait_ready(0);
        run_frame("b2b_00", 0, 8'h00, 2, 0, 1, 1'b1, 8'hFF, -1, 16'd0, -1);
        run_frame("b2b_FF", 0, 8'hFF, 2, 0, 1, 1'b0, 8'h00, -1, 16'd0, -1);

        // Odd parity, two stop bits: 96-cycle frame, parity bit 1
        prescale = 16'd1;
        wait_ready(1);
        run_frame("par_03", 1, 8'h03, 1, 2, 2, 1'b0, 8'h00, -1, 16'd0, -1);

        // Reset in the middle of the 4th data bit (cycles 32..39 of the frame)
        wait_ready(0);
        run_frame("abort_F0", 0, 8'hF0, 1, 0, 1, 1'b0, 8'h00, -1, 16'd0, 36);
        chk("abort mid txd", 32'(txd0), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort txd", 32'(txd0), 32'd1);
        chk("abort busy", 32'(busy0), 32'd0);
        chk("abort tready", 32'(tready0), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort tready_rise", 32'(tready0), 32'd1);
        run_frame("after_A5", 0, 8'hA5, 1, 0, 1, 1'b0, 8'h00, -1, 16'd0, -1);

        // Prescale change mid-frame only affects the following frame
        prescale = 16'd1;
        wait_ready(0);
        run_frame("chg_5A", 0, 8'h5A, 1, 0, 1, 1'b0, 8'h00, 20, 16'd3, -1);
        run_frame("chg_3C", 0, 8'h3C, 3, 0, 1, 1'b0, 8'h00, -1, 16'd0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
